// File: rtl/calc_op_sequencer.sv
// Calculator front end: button sync/debounce, press arbitration, op issue over valid/ready, display scan.
// Optional CALC_AUTO_REPEAT_EN: re-issue the held op every REPEAT_CYCLES while its button stays down.
module calc_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int SCAN_CYCLES     = 16384
`ifdef CALC_AUTO_REPEAT_EN
  , parameter int REPEAT_CYCLES = 4194304
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] button,
  input  logic [3:0] switch_x,
  input  logic [3:0] switch_y,
  input  logic       op_ready,
  output logic       op_valid,
  output logic [1:0] op_code,
  output logic [3:0] op_x,
  output logic [3:0] op_y,
  output logic       mode,
  output logic [7:0] led,
  output logic [1:0] digit_sel,
  output logic [3:0] anode
);

  // state | meaning
  // IDLE  | waiting for a debounced press
  // ISSUE | op_valid high, operands frozen until op_ready
  // HOLD  | op accepted, waiting for all buttons released

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  state_t          state, state_nx;
  logic [3:0]      sync_a, sync_b, stable, press;
  logic [DW-1:0]   deb_cnt [4];
  logic [1:0]      win_idx;
  logic            load_ops, load_code, accept;
  logic [SW-1:0]   scan_cnt;
  logic [1:0]      digit_nx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= button;
      sync_b <= sync_a;
    end
  end

  // press pulses in the same cycle the stable value flips to 1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= sync_b[i];
          press[i]   <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_idx = 2'd3;
    if (press[2]) win_idx = 2'd2;
    if (press[1]) win_idx = 2'd1;
    if (press[0]) win_idx = 2'd0;
  end

`ifdef CALC_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_cnt;
  logic          rpt_hit;

  assign rpt_hit = (state == HOLD) && stable[op_code] && (rpt_cnt == RPT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt <= '0;
    end else if (state != HOLD || !stable[op_code] || rpt_hit) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_ops  = 1'b0;
    load_code = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|press) begin
          load_ops  = 1'b1;
          load_code = 1'b1;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        if (op_ready) begin
          accept   = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
`ifdef CALC_AUTO_REPEAT_EN
        if (rpt_hit) begin
          load_ops = 1'b1;
          state_nx = ISSUE;
        end else
`endif
        if (stable == 4'b0000) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_valid <= 1'b0;
      op_code  <= '0;
      op_x     <= '0;
      op_y     <= '0;
      mode     <= 1'b0;
      led      <= '0;
    end else begin
      op_valid <= (state_nx == ISSUE);
      if (load_code) op_code <= win_idx;
      if (load_ops) begin
        op_x <= switch_x;
        op_y <= switch_y;
        led  <= {switch_x, switch_y};
      end
      if (accept) mode <= (op_code == 2'd3);
    end
  end

  assign digit_nx = digit_sel + 2'd1;

  // anode is registered alongside digit_sel so both change on the same edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_sel <= '0;
      anode     <= 4'b1110;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_sel <= digit_nx;
      anode     <= ~(4'b0001 << digit_nx);
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed and random press sequences against a behavioural model.
// Honours CALC_AUTO_REPEAT_EN for the repeat expectations.
module tb_calc_op_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] button, switch_x, switch_y;
  logic       op_ready;
  logic       op_valid, mode;
  logic [1:0] op_code, digit_sel;
  logic [3:0] op_x, op_y, anode;
  logic [7:0] led;

  int total = 0;
  int bad   = 0;
  int valid_cycles = 0;
  logic [9:0] acc_q [$];

  calc_op_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SCAN_CYCLES(4)
`ifdef CALC_AUTO_REPEAT_EN
    , .REPEAT_CYCLES(16)
`endif
  ) dut (
    .clock(clock), .reset_n(reset_n), .button(button),
    .switch_x(switch_x), .switch_y(switch_y), .op_ready(op_ready),
    .op_valid(op_valid), .op_code(op_code), .op_x(op_x), .op_y(op_y),
    .mode(mode), .led(led), .digit_sel(digit_sel), .anode(anode)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset_n && op_valid) begin
      valid_cycles++;
      if (op_ready) acc_q.push_back({op_code, op_x, op_y});
    end
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (op_valid) begin
        ok = 1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // priority rule: lowest set button index wins
  function automatic logic [1:0] winner(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic chk_last(input string tag, input int exp_n, input logic [1:0] c,
                          input logic [3:0] x, input logic [3:0] y);
    chk({tag, "_count"}, 32'(acc_q.size()), 32'(exp_n));
    if (acc_q.size() > 0) chk({tag, "_op"}, 32'(acc_q[$]), 32'({c, x, y}));
    chk({tag, "_led"}, 32'(led), 32'({x, y}));
    chk({tag, "_mode"}, 32'(mode), 32'(c == 2'd3));
  endtask

  initial begin
    int exp_ops = 0;
    int vc;
    logic [3:0] b, x, y;
    int d;

    reset_n = 1'b0; button = '0; switch_x = '0; switch_y = '0; op_ready = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(6);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_anode", 32'(anode), 32'h0000_000e);
    chk("rst_digit", 32'(digit_sel), 32'd0);
    chk("rst_valid", 32'(op_valid), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_code", 32'(op_code), 32'd0);

    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      chk("scan_digit", 32'(digit_sel), 32'((n / 4) % 4));
      chk("scan_anode", 32'(anode), 32'(4'hf & ~(4'b0001 << ((n / 4) % 4))));
    end

    op_ready = 1'b1;
    vc = valid_cycles;
    for (int i = 0; i < 10; i++) begin
      button[0] = ~button[0];
      cyc(2);
    end
    button = '0;
    cyc(10);
    chk("bounce_valid", 32'(valid_cycles - vc), 32'd0);
    chk("bounce_ops", 32'(acc_q.size()), 32'd0);

    switch_x = 4'd9; switch_y = 4'd5; button = 4'b0001;
    vc = valid_cycles;
    cyc(6);
    chk("add_lat_pre", 32'(op_valid), 32'd0);
    cyc(1);
    chk("add_lat_on", 32'(op_valid), 32'd1);
    chk("add_code", 32'(op_code), 32'd0);
    chk("add_x", 32'(op_x), 32'd9);
    chk("add_y", 32'(op_y), 32'd5);
    cyc(1);
    chk("add_lat_off", 32'(op_valid), 32'd0);
    cyc(4);
    button = '0;
    cyc(12);
    exp_ops++;
    chk("add_pulses", 32'(valid_cycles - vc), 32'd1);
    chk_last("add", exp_ops, 2'd0, 4'd9, 4'd5);

    op_ready = 1'b0; switch_x = 4'd3; switch_y = 4'd12; button = 4'b1010;
    wait_valid("bp_timeout");
    switch_x = 4'd7; switch_y = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_valid", 32'(op_valid), 32'd1);
      chk("bp_code", 32'(op_code), 32'd1);
      chk("bp_x", 32'(op_x), 32'd3);
      chk("bp_y", 32'(op_y), 32'd12);
    end
    chk("bp_no_accept", 32'(acc_q.size()), 32'(exp_ops));
    op_ready = 1'b1;
    cyc(1);
    chk("bp_drop", 32'(op_valid), 32'd0);
    button = '0;
    cyc(12);
    exp_ops++;
    chk_last("bp", exp_ops, 2'd1, 4'd3, 4'd12);

    switch_x = 4'hA; switch_y = 4'h3; button = 4'b1000;
    cyc(12); button = '0; cyc(12);
    exp_ops++;
    chk_last("rot", exp_ops, 2'd3, 4'hA, 4'h3);
    switch_x = 4'h2; switch_y = 4'h6; button = 4'b0100;
    cyc(12); button = '0; cyc(12);
    exp_ops++;
    chk_last("yx", exp_ops, 2'd2, 4'h2, 4'h6);

    op_ready = 1'b0; switch_x = 4'h4; switch_y = 4'h4; button = 4'b0001;
    wait_valid("rstiss_timeout");
    button = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rstiss_valid", 32'(op_valid), 32'd0);
    chk("rstiss_led", 32'(led), 32'd0);
    vc = valid_cycles;
    cyc(2);
    reset_n = 1'b1;
    cyc(20);
    chk("rstiss_after", 32'(valid_cycles - vc), 32'd0);

    for (int t = 0; t < 8; t++) begin
      b = 4'($urandom_range(1, 15));
      x = 4'($urandom);
      y = 4'($urandom);
      d = int'($urandom_range(0, 4));
      op_ready = 1'b0; switch_x = x; switch_y = y; button = b;
      wait_valid("rnd_timeout");
      switch_x = 4'($urandom);
      switch_y = 4'($urandom);
      cyc(d);
      op_ready = 1'b1;
      cyc(1);
      button = '0;
      cyc(12);
      exp_ops++;
      chk_last("rnd", exp_ops, winner(b), x, y);
    end

    op_ready = 1'b1; switch_x = 4'h1; switch_y = 4'h2; button = 4'b0010;
    vc = acc_q.size();
    cyc(60);
    button = '0;
    cyc(14);
`ifdef CALC_AUTO_REPEAT_EN
    chk("repeat_ops", 32'(acc_q.size() - vc >= 3), 32'd1);
`else
    chk("repeat_ops", 32'(acc_q.size() - vc), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
